axi_sram_slave: RTL

- AXI4 responder (slave) with a single 32-bit data path, backed by an internal word-addressed SRAM.
- Serves the core's io_master AR/R/AW/W/B traffic in simulation and in standalone benches; it is the opposite end of the ifu/lsu read and write masters.
- Read and write channels run independent FSMs over shared storage.
- Supports FIXED and INCR bursts, byte strobes, programmable read latency, and SLVERR/DECERR responses.

---
 rtl/axi_sram_slave_pkg.sv | 30 +++
 rtl/axi_sram_slave_mem.sv | 27 ++
 rtl/axi_sram_slave.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI encodings, bus widths and FSM state types for the SRAM-backed AXI responder.
package axi_sram_slave_pkg;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned SIZE_W = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  // WRAP and reserved bursts sequence like FIXED; only INCR moves the address.
  function automatic logic [31:0] next_addr(logic [31:0] a, logic [SIZE_W-1:0] size,
                                            logic [1:0] burst);
    return (burst == BURST_INCR) ? a + (32'd1 << size) : a;
  endfunction

  function automatic logic attr_err(logic [SIZE_W-1:0] size, logic [1:0] burst);
    return (size > 3'd2) || burst[1];
  endfunction

endpackage

// File: rtl/axi_sram_slave_mem.sv
// Word-organised storage: combinational read port, synchronous byte-strobed write port.
module axi_sram_slave_mem #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] i_rd_idx,
  output logic [31:0]   o_rd_data,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_idx,
  input  logic [31:0]   i_wr_data,
  input  logic [3:0]    i_wr_strb
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (i_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (i_wr_strb[b]) r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
      end
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 responder over an internal SRAM; independent read and write FSMs share the storage.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              slv_awvalid_i,
  output logic              slv_awready_o,
  input  logic [31:0]       slv_awaddr_i,
  input  logic [ID_W-1:0]   slv_awid_i,
  input  logic [LEN_W-1:0]  slv_awlen_i,
  input  logic [SIZE_W-1:0] slv_awsize_i,
  input  logic [1:0]        slv_awburst_i,
  input  logic              slv_wvalid_i,
  output logic              slv_wready_o,
  input  logic [31:0]       slv_wdata_i,
  input  logic [3:0]        slv_wstrb_i,
  input  logic              slv_wlast_i,
  output logic              slv_bvalid_o,
  input  logic              slv_bready_i,
  output logic [1:0]        slv_bresp_o,
  output logic [ID_W-1:0]   slv_bid_o,
  input  logic              slv_arvalid_i,
  output logic              slv_arready_o,
  input  logic [31:0]       slv_araddr_i,
  input  logic [ID_W-1:0]   slv_arid_i,
  input  logic [LEN_W-1:0]  slv_arlen_i,
  input  logic [SIZE_W-1:0] slv_arsize_i,
  input  logic [1:0]        slv_arburst_i,
  output logic              slv_rvalid_o,
  input  logic              slv_rready_i,
  output logic [31:0]       slv_rdata_o,
  output logic [1:0]        slv_rresp_o,
  output logic              slv_rlast_o,
  output logic [ID_W-1:0]   slv_rid_o
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [7:0]  LAT_LAST = (RD_LATENCY > 0) ? 8'(RD_LATENCY - 1) : 8'd0;

  function automatic logic in_range(logic [31:0] a);
    return (a - BASE_ADDR) < SPAN;
  endfunction

  function automatic logic [AW-1:0] word_idx(logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return off[AW+1:2];
  endfunction

  // ---------------- read channel ----------------
  rd_state_e         r_rd_state, w_rd_next;
  logic [31:0]       r_rd_addr;
  logic [ID_W-1:0]   r_rd_id;
  logic [LEN_W-1:0]  r_rd_len, r_rd_beat;
  logic [SIZE_W-1:0] r_rd_size;
  logic [1:0]        r_rd_burst;
  logic [7:0]        r_lat_cnt;
  logic [31:0]       r_rdata;
  logic [1:0]        r_rresp;
  logic              r_rlast;
  logic              w_ar_ready, w_rvalid, w_rd_load, w_rd_adv, w_rd_done;
  logic [31:0]       w_rd_lookup, w_mem_rdata;
  logic              w_rd_slv, w_rd_lookup_last;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_rd_state <= R_IDLE;
    else        r_rd_state <= w_rd_next;
  end

  // The beat register is loaded from whichever address becomes visible next,
  // so the lookup address follows the AR inputs, the latched address or the advanced one.
  always_comb begin
    w_rd_next        = r_rd_state;
    w_ar_ready       = 1'b0;
    w_rvalid         = 1'b0;
    w_rd_load        = 1'b0;
    w_rd_adv         = 1'b0;
    w_rd_done        = 1'b0;
    w_rd_lookup      = r_rd_addr;
    w_rd_slv         = attr_err(r_rd_size, r_rd_burst);
    w_rd_lookup_last = (r_rd_beat == r_rd_len);
    case (r_rd_state)
      R_IDLE: begin
        w_ar_ready       = 1'b1;
        w_rd_lookup      = slv_araddr_i;
        w_rd_slv         = attr_err(slv_arsize_i, slv_arburst_i);
        w_rd_lookup_last = (slv_arlen_i == '0);
        if (slv_arvalid_i) begin
          if (RD_LATENCY == 0) begin
            w_rd_next = R_DATA;
            w_rd_load = 1'b1;
          end else begin
            w_rd_next = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_rd_next = R_DATA;
          w_rd_load = 1'b1;
        end
      end
      R_DATA: begin
        w_rvalid         = 1'b1;
        w_rd_lookup      = next_addr(r_rd_addr, r_rd_size, r_rd_burst);
        w_rd_lookup_last = ((r_rd_beat + 8'd1) == r_rd_len);
        if (slv_rready_i) begin
          if (r_rlast) begin
            w_rd_next = R_IDLE;
            w_rd_done = 1'b1;
          end else begin
            w_rd_adv  = 1'b1;
            w_rd_load = 1'b1;
          end
        end
      end
      default: w_rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd_addr  <= '0;
      r_rd_id    <= '0;
      r_rd_len   <= '0;
      r_rd_size  <= '0;
      r_rd_burst <= '0;
      r_rd_beat  <= '0;
      r_lat_cnt  <= '0;
      r_rdata    <= '0;
      r_rresp    <= '0;
      r_rlast    <= 1'b0;
    end else begin
      if (r_rd_state == R_IDLE && slv_arvalid_i) begin
        r_rd_addr  <= slv_araddr_i;
        r_rd_id    <= slv_arid_i;
        r_rd_len   <= slv_arlen_i;
        r_rd_size  <= slv_arsize_i;
        r_rd_burst <= slv_arburst_i;
        r_rd_beat  <= '0;
        r_lat_cnt  <= '0;
      end
      if (r_rd_state == R_WAIT) r_lat_cnt <= r_lat_cnt + 8'd1;
      if (w_rd_adv) begin
        r_rd_addr <= w_rd_lookup;
        r_rd_beat <= r_rd_beat + 8'd1;
      end
      if (w_rd_load) begin
        r_rdata <= in_range(w_rd_lookup) ? w_mem_rdata : '0;
        r_rresp <= !in_range(w_rd_lookup) ? RESP_DECERR :
                   w_rd_slv               ? RESP_SLVERR : RESP_OKAY;
        r_rlast <= w_rd_lookup_last;
      end else if (w_rd_done) begin
        r_rlast <= 1'b0;
      end
    end
  end

  // ---------------- write channel ----------------
  wr_state_e         r_wr_state, w_wr_next;
  logic [31:0]       r_wr_addr;
  logic [ID_W-1:0]   r_wr_id;
  logic [LEN_W-1:0]  r_wr_len, r_wr_beat;
  logic [SIZE_W-1:0] r_wr_size;
  logic [1:0]        r_wr_burst;
  logic              r_wr_past, r_wr_slv, r_wr_dec;
  logic [1:0]        r_bresp;
  logic              w_aw_ready, w_wready, w_bvalid, w_w_hs, w_we;
  logic              w_wr_in_range, w_wr_dec_n, w_wr_slv_n;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_wr_state <= W_IDLE;
    else        r_wr_state <= w_wr_next;
  end

  always_comb begin
    w_wr_next     = r_wr_state;
    w_aw_ready    = 1'b0;
    w_wready      = 1'b0;
    w_bvalid      = 1'b0;
    w_w_hs        = 1'b0;
    w_wr_in_range = in_range(r_wr_addr);
    w_we          = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        w_aw_ready = 1'b1;
        if (slv_awvalid_i) w_wr_next = W_DATA;
      end
      W_DATA: begin
        w_wready = 1'b1;
        if (slv_wvalid_i) begin
          w_w_hs = 1'b1;
          w_we   = !r_wr_past && w_wr_in_range;
          if (slv_wlast_i) w_wr_next = W_RESP;
        end
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (slv_bready_i) w_wr_next = W_IDLE;
      end
      default: w_wr_next = W_IDLE;
    endcase
    w_wr_dec_n = r_wr_dec | (!r_wr_past & !w_wr_in_range);
    w_wr_slv_n = r_wr_slv | r_wr_past | (r_wr_beat != r_wr_len);
  end

  // Once beat len has been taken the beat counter freezes and r_wr_past marks
  // every further beat as surplus, so long bursts never wrap the counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_addr  <= '0;
      r_wr_id    <= '0;
      r_wr_len   <= '0;
      r_wr_size  <= '0;
      r_wr_burst <= '0;
      r_wr_beat  <= '0;
      r_wr_past  <= 1'b0;
      r_wr_slv   <= 1'b0;
      r_wr_dec   <= 1'b0;
      r_bresp    <= '0;
    end else begin
      if (r_wr_state == W_IDLE && slv_awvalid_i) begin
        r_wr_addr  <= slv_awaddr_i;
        r_wr_id    <= slv_awid_i;
        r_wr_len   <= slv_awlen_i;
        r_wr_size  <= slv_awsize_i;
        r_wr_burst <= slv_awburst_i;
        r_wr_beat  <= '0;
        r_wr_past  <= 1'b0;
        r_wr_slv   <= attr_err(slv_awsize_i, slv_awburst_i);
        r_wr_dec   <= 1'b0;
      end
      if (w_w_hs) begin
        r_wr_addr <= next_addr(r_wr_addr, r_wr_size, r_wr_burst);
        if (!r_wr_past) begin
          if (r_wr_beat == r_wr_len) r_wr_past <= 1'b1;
          else                       r_wr_beat <= r_wr_beat + 8'd1;
          if (!w_wr_in_range) r_wr_dec <= 1'b1;
        end else begin
          r_wr_slv <= 1'b1;
        end
        if (slv_wlast_i) begin
          r_bresp <= w_wr_dec_n ? RESP_DECERR :
                     w_wr_slv_n ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  axi_sram_slave_mem #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_mem (
    .clk_i    (clk_i),
    .i_rd_idx (word_idx(w_rd_lookup)),
    .o_rd_data(w_mem_rdata),
    .i_we     (w_we),
    .i_wr_idx (word_idx(r_wr_addr)),
    .i_wr_data(slv_wdata_i),
    .i_wr_strb(slv_wstrb_i)
  );

  assign slv_awready_o = w_aw_ready;
  assign slv_wready_o  = w_wready;
  assign slv_bvalid_o  = w_bvalid;
  assign slv_bresp_o   = r_bresp;
  assign slv_bid_o     = r_wr_id;
  assign slv_arready_o = w_ar_ready;
  assign slv_rvalid_o  = w_rvalid;
  assign slv_rdata_o   = r_rdata;
  assign slv_rresp_o   = r_rresp;
  assign slv_rlast_o   = r_rlast;
  assign slv_rid_o     = r_rd_id;

endmodule
